// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style bus responder: opcode classes,
// bus bundle type and small address/status helpers.
package lcd_pkg;

    localparam int          DDRAM_DEPTH = 32;
    localparam logic [7:0]  FILL_CHAR   = 8'h20;
    localparam logic [6:0]  LINE2_BASE  = 7'h40;

    localparam logic [7:0]  OP_DDRAM_MASK = 8'h80;
    localparam logic [7:0]  OP_CGRAM_MASK = 8'h40;
    localparam logic [7:0]  OP_FUNC_MASK  = 8'h20;
    localparam logic [7:0]  OP_SHIFT_MASK = 8'h10;
    localparam logic [7:0]  OP_DISP_MASK  = 8'h08;
    localparam logic [7:0]  OP_ENTRY_MASK = 8'h04;
    localparam logic [7:0]  OP_HOME_MASK  = 8'h02;
    localparam logic [7:0]  OP_CLEAR_MASK = 8'h01;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISP,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } op_e;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] db;
    } bus_t;

    // The instruction class is set by the most significant 1 in the byte.
    function automatic op_e decode_op(input logic [7:0] db);
        if      ((db & OP_DDRAM_MASK) != 8'h00) return OP_DDRAM;
        else if ((db & OP_CGRAM_MASK) != 8'h00) return OP_CGRAM;
        else if ((db & OP_FUNC_MASK)  != 8'h00) return OP_FUNC;
        else if ((db & OP_SHIFT_MASK) != 8'h00) return OP_SHIFT;
        else if ((db & OP_DISP_MASK)  != 8'h00) return OP_DISP;
        else if ((db & OP_ENTRY_MASK) != 8'h00) return OP_ENTRY;
        else if ((db & OP_HOME_MASK)  != 8'h00) return OP_HOME;
        else if ((db & OP_CLEAR_MASK) != 8'h00) return OP_CLEAR;
        else                                    return OP_NOP;
    endfunction

    // Map a 7-bit DDRAM address (0x00-0x0F line 1, 0x40-0x4F line 2) to the 5-bit AC.
    function automatic logic [4:0] ddram_to_ac(input logic [6:0] addr);
        logic line2;
        line2 = (addr & LINE2_BASE) != 7'h00;
        return {line2, addr[3:0]};
    endfunction

    function automatic logic [4:0] step_ac(input logic [4:0] ac, input logic inc);
        return inc ? ac + 5'd1 : ac - 5'd1;
    endfunction

    function automatic logic [7:0] status_byte(input logic busy, input logic [4:0] ac);
        return {busy, ac[4], 2'b00, ac[3:0]};
    endfunction

endpackage

// File: rtl/lcd_bus_responder_sync.sv
// Two-flop synchronizer for the whole LCD bus bundle plus E falling-edge
// detection; the strobe carries RS/RW/DB from the sample taken before E fell.
module lcd_strobe_sync
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] db,
    output logic       e_s,
    output logic       rs_s,
    output logic       rw_s,
    output logic [7:0] db_s,
    output logic       strb,
    output logic       strb_rs,
    output logic       strb_rw,
    output logic [7:0] strb_db
);

    bus_t sync1_q, sync1_d;
    bus_t sync2_q, sync2_d;
    bus_t prev_q,  prev_d;

    always_comb begin
        sync1_d = '{e: e, rs: rs, rw: rw, db: db};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign e_s     = sync2_q.e;
    assign rs_s    = sync2_q.rs;
    assign rw_s    = sync2_q.rw;
    assign db_s    = sync2_q.db;
    assign strb    = prev_q.e & ~sync2_q.e;
    assign strb_rs = prev_q.rs;
    assign strb_rw = prev_q.rw;
    assign strb_db = prev_q.db;

endmodule

// File: rtl/lcd_bus_responder.sv
// Display-side HD44780-style bus responder: instruction decode, 32-byte DDRAM,
// address counter, mode flags, busy-flag timing and read-back.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_INS_CYCLES = 40,
    parameter int BUSY_CLR_CYCLES = 1520
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RS,
    input  logic       E,
    input  logic       RW,
    input  logic [7:0] DB_in,
    output logic [7:0] DB_out,
    output logic       DB_oe,
    output logic       busy,
    output logic [4:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       shift_mode,
    output logic       two_line,
    output logic       dl8,
    input  logic [4:0] dbg_addr,
    output logic [7:0] dbg_char,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       err_busy
);

    localparam int BUSY_MAX = (BUSY_CLR_CYCLES > BUSY_INS_CYCLES) ? BUSY_CLR_CYCLES : BUSY_INS_CYCLES;
    localparam int CNT_W    = $clog2(BUSY_MAX + 1);

    logic       e_s, rs_s, rw_s;
    logic [7:0] db_s;
    logic       strb, strb_rs, strb_rw;
    logic [7:0] strb_db;

    lcd_strobe_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .e       (E),
        .rs      (RS),
        .rw      (RW),
        .db      (DB_in),
        .e_s     (e_s),
        .rs_s    (rs_s),
        .rw_s    (rw_s),
        .db_s    (db_s),
        .strb    (strb),
        .strb_rs (strb_rs),
        .strb_rw (strb_rw),
        .strb_db (strb_db)
    );

    logic [4:0]       ac_q, ac_d;
    logic             disp_on_q, disp_on_d;
    logic             cursor_on_q, cursor_on_d;
    logic             blink_on_q, blink_on_d;
    logic             inc_mode_q, inc_mode_d;
    logic             shift_mode_q, shift_mode_d;
    logic             two_line_q, two_line_d;
    logic             dl8_q, dl8_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic             fill_active_q, fill_active_d;
    logic [4:0]       fill_idx_q, fill_idx_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             cmd_rs_q, cmd_rs_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             err_busy_q, err_busy_d;
    logic [7:0]       db_out_q, db_out_d;
    logic             db_oe_q, db_oe_d;

    logic [7:0]       mem_q [DDRAM_DEPTH];
    logic             mem_we;
    logic [4:0]       mem_waddr;
    logic [7:0]       mem_wdata;
    logic             busy_now;
    logic             status_read;
    op_e              op;

    assign busy_now    = (busy_cnt_q != '0);
    assign status_read = strb_rw & ~strb_rs;
    assign op          = decode_op(strb_db);

    always_comb begin
        ac_d          = ac_q;
        disp_on_d     = disp_on_q;
        cursor_on_d   = cursor_on_q;
        blink_on_d    = blink_on_q;
        inc_mode_d    = inc_mode_q;
        shift_mode_d  = shift_mode_q;
        two_line_d    = two_line_q;
        dl8_d         = dl8_q;
        busy_cnt_d    = busy_now ? busy_cnt_q - 1'b1 : busy_cnt_q;
        fill_active_d = fill_active_q;
        fill_idx_d    = fill_idx_q;
        cmd_valid_d   = 1'b0;
        cmd_rs_d      = cmd_rs_q;
        cmd_byte_d    = cmd_byte_q;
        err_busy_d    = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = ac_q;
        mem_wdata     = strb_db;

        // Read data is presented only while the synchronized E and RW are both high.
        db_oe_d  = e_s & rw_s;
        db_out_d = 8'h00;
        if (db_oe_d) begin
            db_out_d = rs_s ? mem_q[ac_q] : status_byte(busy_now, ac_q);
        end

        if (fill_active_q) begin
            mem_we     = 1'b1;
            mem_waddr  = fill_idx_q;
            mem_wdata  = FILL_CHAR;
            fill_idx_d = fill_idx_q + 5'd1;
            if (fill_idx_q == 5'(DDRAM_DEPTH - 1)) begin
                fill_active_d = 1'b0;
            end
        end

        if (strb) begin
            if (status_read) begin
                cmd_valid_d = 1'b1;
                cmd_rs_d    = 1'b0;
                cmd_byte_d  = strb_db;
            end else if (busy_now) begin
                err_busy_d = 1'b1;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_rs_d    = strb_rs;
                cmd_byte_d  = strb_db;
                busy_cnt_d  = CNT_W'(BUSY_INS_CYCLES);
                if (strb_rs) begin
                    if (!strb_rw) begin
                        mem_we    = 1'b1;
                        mem_waddr = ac_q;
                        mem_wdata = strb_db;
                    end
                    ac_d = step_ac(ac_q, inc_mode_q);
                end else begin
                    unique case (op)
                        OP_DDRAM: ac_d = ddram_to_ac(strb_db[6:0]);
                        OP_FUNC: begin
                            dl8_d      = strb_db[4];
                            two_line_d = strb_db[3];
                        end
                        OP_SHIFT: begin
                            if (!strb_db[3]) begin
                                ac_d = step_ac(ac_q, strb_db[2]);
                            end
                        end
                        OP_DISP: begin
                            disp_on_d   = strb_db[2];
                            cursor_on_d = strb_db[1];
                            blink_on_d  = strb_db[0];
                        end
                        OP_ENTRY: begin
                            inc_mode_d   = strb_db[1];
                            shift_mode_d = strb_db[0];
                        end
                        OP_HOME: begin
                            ac_d       = 5'd0;
                            busy_cnt_d = CNT_W'(BUSY_CLR_CYCLES);
                        end
                        OP_CLEAR: begin
                            ac_d          = 5'd0;
                            inc_mode_d    = 1'b1;
                            busy_cnt_d    = CNT_W'(BUSY_CLR_CYCLES);
                            fill_active_d = 1'b1;
                            fill_idx_d    = 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Reset re-arms the power-on clear: busy loaded with the long time, fill from entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ac_q          <= 5'd0;
            disp_on_q     <= 1'b0;
            cursor_on_q   <= 1'b0;
            blink_on_q    <= 1'b0;
            inc_mode_q    <= 1'b1;
            shift_mode_q  <= 1'b0;
            two_line_q    <= 1'b0;
            dl8_q         <= 1'b1;
            busy_cnt_q    <= CNT_W'(BUSY_CLR_CYCLES);
            fill_active_q <= 1'b1;
            fill_idx_q    <= 5'd0;
            cmd_valid_q   <= 1'b0;
            cmd_rs_q      <= 1'b0;
            cmd_byte_q    <= 8'h00;
            err_busy_q    <= 1'b0;
            db_out_q      <= 8'h00;
            db_oe_q       <= 1'b0;
        end else begin
            ac_q          <= ac_d;
            disp_on_q     <= disp_on_d;
            cursor_on_q   <= cursor_on_d;
            blink_on_q    <= blink_on_d;
            inc_mode_q    <= inc_mode_d;
            shift_mode_q  <= shift_mode_d;
            two_line_q    <= two_line_d;
            dl8_q         <= dl8_d;
            busy_cnt_q    <= busy_cnt_d;
            fill_active_q <= fill_active_d;
            fill_idx_q    <= fill_idx_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_rs_q      <= cmd_rs_d;
            cmd_byte_q    <= cmd_byte_d;
            err_busy_q    <= err_busy_d;
            db_out_q      <= db_out_d;
            db_oe_q       <= db_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign DB_out     = db_out_q;
    assign DB_oe      = db_oe_q;
    assign busy       = busy_now;
    assign ac         = ac_q;
    assign disp_on    = disp_on_q;
    assign cursor_on  = cursor_on_q;
    assign blink_on   = blink_on_q;
    assign inc_mode   = inc_mode_q;
    assign shift_mode = shift_mode_q;
    assign two_line   = two_line_q;
    assign dl8        = dl8_q;
    assign dbg_char   = mem_q[dbg_addr];
    assign cmd_valid  = cmd_valid_q;
    assign cmd_rs     = cmd_rs_q;
    assign cmd_byte   = cmd_byte_q;
    assign err_busy   = err_busy_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed bus sequences plus random accesses
// compared against a behavioural display model.
`timescale 1ns/1ps
module tb_lcd_bus_responder;

    localparam int INS = 40;
    localparam int CLR = 1520;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RS = 1'b0, E = 1'b0, RW = 1'b0;
    logic [7:0] DB_in = 8'h00;
    logic [7:0] DB_out;
    logic       DB_oe, busy;
    logic [4:0] ac;
    logic       disp_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, dl8;
    logic [4:0] dbg_addr = 5'd0;
    logic [7:0] dbg_char;
    logic       cmd_valid, cmd_rs, err_busy;
    logic [7:0] cmd_byte;

    always #5 clk = ~clk;

    lcd_bus_responder #(.BUSY_INS_CYCLES(INS), .BUSY_CLR_CYCLES(CLR)) dut (
        .clk(clk), .rst(rst), .RS(RS), .E(E), .RW(RW), .DB_in(DB_in),
        .DB_out(DB_out), .DB_oe(DB_oe), .busy(busy), .ac(ac),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .inc_mode(inc_mode), .shift_mode(shift_mode), .two_line(two_line), .dl8(dl8),
        .dbg_addr(dbg_addr), .dbg_char(dbg_char),
        .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte), .err_busy(err_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural display model ----------------
    logic [7:0] m_ram [32];
    logic [4:0] m_ac;
    logic       m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_dl8;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
        m_ac = 0; m_disp = 0; m_cur = 0; m_blink = 0;
        m_inc = 1; m_shift = 0; m_two = 0; m_dl8 = 1;
    endtask

    function automatic logic [6:0] m_flags();
        return {m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_dl8};
    endfunction

    function automatic logic [6:0] dut_flags();
        return {disp_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, dl8};
    endfunction

    // Applies one accepted access; returns busy duration and expected read byte.
    task automatic model_access(input bit rs_i, input bit rw_i, input logic [7:0] d,
                                input bit busy_now, output int blen, output logic [7:0] rd);
        rd = 8'h00;
        blen = INS;
        if (rw_i && !rs_i) begin
            rd = {busy_now, m_ac[4], 2'b00, m_ac[3:0]};
            blen = 0;
        end else if (rs_i) begin
            if (rw_i) rd = m_ram[m_ac];
            else      m_ram[m_ac] = d;
            m_ac = m_inc ? m_ac + 5'd1 : m_ac - 5'd1;
        end else if (d[7]) m_ac = {d[6], d[3:0]};
        else if (d[6]) ;
        else if (d[5]) begin m_dl8 = d[4]; m_two = d[3]; end
        else if (d[4]) begin if (!d[3]) m_ac = d[2] ? m_ac + 5'd1 : m_ac - 5'd1; end
        else if (d[3]) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        else if (d[2]) begin m_inc = d[1]; m_shift = d[0]; end
        else if (d[1]) begin m_ac = 0; blen = CLR; end
        else if (d[0]) begin
            for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
            m_ac = 0; m_inc = 1; blen = CLR;
        end
    endtask

    // ---------------- bus driver ----------------
    bit         bc_valid, bc_err, bc_oe, bc_oe_after, bc_cmd_rs;
    logic [7:0] bc_rd, bc_cmd_byte;
    int         bc_blen;

    task automatic bus_cycle(input bit rs_i, input bit rw_i, input logic [7:0] d, input bit wait_idle);
        @(negedge clk);
        RS = rs_i; RW = rw_i; DB_in = d; E = 1'b1;
        repeat (5) @(negedge clk);
        bc_oe = DB_oe; bc_rd = DB_out;
        E = 1'b0;
        bc_valid = 0; bc_err = 0; bc_blen = 0;
        for (int i = 0; i < 10 && !bc_valid && !bc_err; i++) begin
            @(negedge clk);
            bc_valid = cmd_valid; bc_err = err_busy;
        end
        bc_oe_after = DB_oe; bc_cmd_rs = cmd_rs; bc_cmd_byte = cmd_byte;
        RS = 1'b0; RW = 1'b0; DB_in = 8'h00;
        if (bc_valid && wait_idle) begin
            while (busy && bc_blen < 3000) begin
                bc_blen++;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle_chk(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin n++; @(negedge clk); end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_access(input string tag, input bit rs_i, input bit rw_i, input logic [7:0] d,
                             input bit expect_refuse, input bit busy_now, input bit wait_idle);
        int exp_blen;
        logic [7:0] exp_rd;
        bus_cycle(rs_i, rw_i, d, wait_idle);
        if (expect_refuse) begin
            chk({tag, "_err"}, bc_err, 1);
            chk({tag, "_novalid"}, bc_valid, 0);
        end else begin
            model_access(rs_i, rw_i, d, busy_now, exp_blen, exp_rd);
            chk({tag, "_valid"}, bc_valid, 1);
            chk({tag, "_cmd_rs"}, bc_cmd_rs, rs_i);
            if (!rw_i) chk({tag, "_cmd_byte"}, bc_cmd_byte, d);
            if (rw_i) begin
                chk({tag, "_oe"}, bc_oe, 1);
                chk({tag, "_rd"}, bc_rd, exp_rd);
                chk({tag, "_oe_off"}, bc_oe_after, 0);
            end
            if (wait_idle) chk({tag, "_busy_len"}, bc_blen, exp_blen);
        end
        chk({tag, "_ac"}, ac, m_ac);
        chk({tag, "_flags"}, dut_flags(), m_flags());
    endtask

    task automatic ram_chk(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("%s_ram%0d", tag, i), dbg_char, m_ram[i]);
        end
    endtask

    task automatic reset_vals_chk(input string tag);
        chk({tag, "_db_out"}, DB_out, 0);
        chk({tag, "_db_oe"}, DB_oe, 0);
        chk({tag, "_ac"}, ac, 0);
        chk({tag, "_flags"}, dut_flags(), 7'b0001001);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_err_busy"}, err_busy, 0);
        chk({tag, "_cmd_byte"}, cmd_byte, 0);
        chk({tag, "_cmd_rs"}, cmd_rs, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic release_chk(input string tag);
        int n;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_por_busy_len"}, n, CLR);
        model_reset();
        chk({tag, "_ac"}, ac, 0);
        ram_chk(tag);
    endtask

    bit         r_rs, r_rw, r_burst;
    logic [7:0] r_d;
    int         kind;

    initial begin
        // Reset state and power-on clear
        repeat (4) @(negedge clk);
        reset_vals_chk("rst");
        release_chk("por");

        // Initialisation sequence
        do_access("init38", 0, 0, 8'h38, 0, 0, 1);
        do_access("init0F", 0, 0, 8'h0F, 0, 0, 1);
        do_access("init06", 0, 0, 8'h06, 0, 0, 1);
        do_access("init01", 0, 0, 8'h01, 0, 0, 1);
        chk("init_flags", dut_flags(), 7'b1111011);

        // Data on both lines
        do_access("wrH", 1, 0, 8'h48, 0, 0, 1);
        do_access("wrI", 1, 0, 8'h49, 0, 0, 1);
        do_access("addrC0", 0, 0, 8'hC0, 0, 0, 1);
        do_access("wrX", 1, 0, 8'h58, 0, 0, 1);
        chk("line_ac", ac, 17);
        ram_chk("lines");

        // Decrement through the top of line 2, then wrap 31->0
        do_access("addrCF", 0, 0, 8'hCF, 0, 0, 1);
        do_access("dec_mode", 0, 0, 8'h04, 0, 0, 1);
        do_access("dec_wr1", 1, 0, 8'h31, 0, 0, 1);
        chk("dec_ac30", ac, 30);
        do_access("dec_wr2", 1, 0, 8'h32, 0, 0, 1);
        chk("dec_ac29", ac, 29);
        do_access("inc_mode", 0, 0, 8'h06, 0, 0, 1);
        do_access("addrCF2", 0, 0, 8'hCF, 0, 0, 1);
        do_access("wrap_wr", 1, 0, 8'h33, 0, 0, 1);
        chk("wrap_ac0", ac, 0);

        // Strobe while busy is refused; status read during busy is answered
        do_access("bz_wr", 1, 0, 8'h41, 0, 0, 0);
        do_access("bz_drop", 1, 0, 8'h42, 1, 1, 0);
        do_access("bz_stat", 0, 1, 8'h00, 0, 1, 0);
        chk("bz_stat_bit7", bc_rd[7], 1);
        wait_idle_chk("bz");
        ram_chk("bz");
        do_access("rd_addr", 0, 0, 8'h80, 0, 0, 1);
        do_access("rd_data", 1, 1, 8'h00, 0, 0, 1);
        chk("rd_ac_inc", ac, 1);
        do_access("stat_idle", 0, 1, 8'h00, 0, 0, 1);

        // Random accesses
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            r_rs = 0; r_rw = 0; r_d = 8'($urandom_range(0, 255));
            case (kind)
                0: r_rs = 1;
                1: r_d = 8'h80 | 8'($urandom_range(0, 127));
                2: r_d = 8'h04 | 8'($urandom_range(0, 3));
                3: r_d = 8'h08 | 8'($urandom_range(0, 7));
                4: r_d = 8'h10 | 8'($urandom_range(0, 15));
                5: r_d = 8'h20 | 8'($urandom_range(0, 31));
                6: begin r_rw = 1; r_d = 8'h00; end
                7: begin r_rs = 1; r_rw = 1; r_d = 8'h00; end
                8: r_d = ($urandom_range(0, 1) == 0) ? 8'h00 : (8'h40 | 8'($urandom_range(0, 63)));
                default: begin
                    if ($urandom_range(0, 2) == 0) r_d = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
                    else r_rs = 1;
                end
            endcase
            r_burst = ($urandom_range(0, 4) == 0) && !(r_rw && !r_rs);
            do_access($sformatf("rnd%0d", it), r_rs, r_rw, r_d, 0, 0, !r_burst);
            if (r_burst) begin
                do_access($sformatf("rnd%0d_drop", it), 1, 0, 8'($urandom_range(0, 255)), 1, 1, 0);
                wait_idle_chk($sformatf("rnd%0d", it));
            end
        end
        ram_chk("rnd");

        // Fill DDRAM with non-blank data, then reset in the middle of a clear
        do_access("pre_addr", 0, 0, 8'h80, 0, 0, 1);
        do_access("pre_inc", 0, 0, 8'h06, 0, 0, 1);
        for (int i = 0; i < 32; i++) do_access($sformatf("pre%0d", i), 1, 0, 8'h61 + 8'(i), 0, 0, 1);
        do_access("mid_clr", 0, 0, 8'h01, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        reset_vals_chk("midrst");
        release_chk("midrel");
        do_access("post_wr", 1, 0, 8'h5A, 0, 0, 1);
        ram_chk("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
